// File: rtl/trng_pkg.sv
// Shared types and constants for the ring-oscillator TRNG sequencing controller.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FAULT   = 3'd4
    } trng_state_e;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DIV       = 16;
    localparam int DEF_WARMUP    = 64;
    localparam int DEF_RCT_LIMIT = 32;

    // The run counter must be able to hold RCT_LIMIT itself.
    function automatic int run_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/trng_if.sv
// Word output channel of the TRNG controller.
// A word transfers on every rising clk edge where valid && ready; once raised,
// valid stays high and data stays stable until that transfer, and valid never depends on ready.
interface trng_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/trng_rct.sv
// Repetition-count health test: tracks the run of identical samples and pulses
// fail on the strobe whose run length reaches RCT_LIMIT.
module trng_rct
    import trng_pkg::*;
#(
    parameter int RCT_LIMIT = DEF_RCT_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic strobe,
    input  logic sample,
    output logic fail
);
    localparam int            RW    = run_width(RCT_LIMIT);
    localparam logic [RW-1:0] LIMIT = RW'(RCT_LIMIT);

    logic [RW-1:0] run;
    logic [RW-1:0] run_nxt;
    logic          last;

    // A run of zero marks "no sample yet", so the first strobe starts a run of one.
    always_comb begin
        run_nxt = run;
        if (run == '0 || sample != last) begin
            run_nxt = RW'(1);
        end else if (run != LIMIT) begin
            run_nxt = run + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run  <= '0;
            last <= 1'b0;
        end else if (strobe) begin
            run  <= run_nxt;
            last <= sample;
        end
    end

    assign fail = strobe && (run_nxt == LIMIT);

endmodule

// File: rtl/trng_ctrl.sv
// Sequencer for the ring-oscillator sampler: sample-clock divider, input synchroniser,
// warm-up discard, word packing, health-test fault handling and output handshake.
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIV       = DEF_DIV,
    parameter int WARMUP    = DEF_WARMUP,
    parameter int RCT_LIMIT = DEF_RCT_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        raw_bit,
    output logic        samp_clk,
    output logic        busy,
    output logic        fault,
    output trng_state_e state_dbg,
    trng_if.master      dout
);
    localparam int            DW       = $clog2(DIV);
    localparam int            CW       = $clog2(((WARMUP > WIDTH) ? WARMUP : WIDTH) + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);

    trng_state_e      state;
    logic [DW-1:0]    div_cnt;
    logic [CW-1:0]    cnt;
    logic             sync1, sync2;
    logic [WIDTH-2:0] sh;
    logic [WIDTH-1:0] sh_full;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             fault_q;
    logic             running;
    logic             strobe;
    logic             rct_fail;

    assign running  = (state == ST_WARMUP) || (state == ST_COLLECT) || (state == ST_PRESENT);
    assign strobe   = running && (div_cnt == DIV_LAST);
    assign samp_clk = running && (div_cnt >= DIV_HALF);
    assign sh_full  = {sh, sync2};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_bit;
            sync2 <= sync1;
        end
    end

    trng_rct #(.RCT_LIMIT(RCT_LIMIT)) u_rct (
        .clk    (clk),
        .rst    (rst),
        .clear  (!en || state == ST_IDLE),
        .strobe (strobe),
        .sample (sync2),
        .fail   (rct_fail)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            cnt     <= '0;
            sh      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (!en) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_WARMUP;
                    div_cnt <= '0;
                    cnt     <= '0;
                end
                ST_FAULT: begin
                    div_cnt <= '0;
                end
                default: begin
                    div_cnt <= strobe ? '0 : div_cnt + DW'(1);
                    if (state == ST_PRESENT && valid_q && dout.ready) begin
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_COLLECT;
                    end
                    // A failing strobe overrides packing; a same-edge handshake above still counts.
                    if (strobe) begin
                        if (rct_fail) begin
                            state   <= ST_FAULT;
                            fault_q <= 1'b1;
                            valid_q <= 1'b0;
                            cnt     <= '0;
                            div_cnt <= '0;
                        end else if (state == ST_WARMUP) begin
                            if (cnt == CW'(WARMUP - 1)) begin
                                cnt   <= '0;
                                state <= ST_COLLECT;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (state == ST_COLLECT) begin
                            sh <= sh_full[WIDTH-2:0];
                            if (cnt == CW'(WIDTH - 1)) begin
                                data_q  <= sh_full;
                                valid_q <= 1'b1;
                                cnt     <= '0;
                                state   <= ST_PRESENT;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign fault      = fault_q;
    assign state_dbg  = state;
    assign dout.data  = data_q;
    assign dout.valid = valid_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Self-checking bench for trng_ctrl: a sample-level reference model feeds an expected-word
// queue and per-cycle output expectations; a negedge monitor compares against the DUT.
module tb_trng_ctrl;
    import trng_pkg::*;

    localparam int WIDTH     = 8;
    localparam int DIV       = 4;
    localparam int WARMUP    = 4;
    localparam int RCT_LIMIT = 6;
    localparam int FIRST_LAT = (WARMUP + WIDTH) * DIV;

    typedef bit bitq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        raw_bit;
    logic        samp_clk;
    logic        busy;
    logic        fault;
    trng_state_e state_dbg;

    trng_if #(.WIDTH(WIDTH)) bus ();

    trng_ctrl #(
        .WIDTH     (WIDTH),
        .DIV       (DIV),
        .WARMUP    (WARMUP),
        .RCT_LIMIT (RCT_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .raw_bit   (raw_bit),
        .samp_clk  (samp_clk),
        .busy      (busy),
        .fault     (fault),
        .state_dbg (state_dbg),
        .dout      (bus.master)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int               vectors     = 0;
    int               miscompares = 0;
    logic [WIDTH-1:0] exp_q[$];

    // ---------------- reference model ----------------
    int               g = -1;
    bit               raw_hist[$];
    bit               on;
    int               on_since;
    bit               m_fault;
    bit               pending;
    bit               was_pending;
    bit               first_seen;
    logic [WIDTH-1:0] m_word;
    logic [WIDTH-1:0] w;
    bit               samples[$];
    bit               coll[$];
    bit               b;
    int               run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, g);
        end
    endtask

    // Strobe n of a session lands DIV*n edges after the enable edge and sees raw_bit
    // as it was two edges earlier; runs and words come straight from the sample list.
    always @(posedge clk) begin
        g++;
        raw_hist.push_back(raw_bit);
        if (rst || !en) begin
            if (pending && !bus.ready) void'(exp_q.pop_back());
            pending = 1'b0;
            on      = 1'b0;
            m_fault = 1'b0;
            samples.delete();
            coll.delete();
        end else if (!on) begin
            on         = 1'b1;
            on_since   = g;
            first_seen = 1'b0;
            samples.delete();
            coll.delete();
        end else if (!m_fault) begin
            was_pending = pending;
            if (pending && bus.ready) pending = 1'b0;
            if ((g - on_since) % DIV == 0) begin
                b = raw_hist[g-2];
                samples.push_back(b);
                run = 0;
                for (int i = samples.size() - 1; i >= 0 && samples[i] == b; i--) run++;
                if (run >= RCT_LIMIT) begin
                    m_fault = 1'b1;
                    if (pending) begin
                        void'(exp_q.pop_back());
                        pending = 1'b0;
                    end
                    coll.delete();
                end else if (samples.size() > WARMUP && !was_pending) begin
                    coll.push_back(b);
                    if (coll.size() == WIDTH) begin
                        w = '0;
                        foreach (coll[i]) w = {w[WIDTH-2:0], coll[i]};
                        m_word = w;
                        exp_q.push_back(w);
                        pending = 1'b1;
                        coll.delete();
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (g >= 0) begin
            check("valid", bus.valid, pending);
            check("fault", fault, m_fault);
            check("busy", busy, on);
            check("samp_clk", samp_clk,
                  on && !m_fault && ((g - on_since) % DIV >= DIV / 2));
            if (pending) check("data_hold", bus.data, m_word);
            if (bus.valid && on && !first_seen) begin
                first_seen = 1'b1;
                check("first_valid_latency", g - on_since, FIRST_LAT);
            end
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL word: got %0h, expected no transfer (edge %0d)", bus.data, g);
                end else begin
                    check("word", bus.data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    bitq_t seq;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        en        = 1'b0;
        bus.ready = 1'b0;
        step(n);
    endtask

    task automatic start();
        en = 1'b1;
        step(1);
    endtask

    task automatic add_alt(input int n, input bit first);
        bit v = first;
        for (int i = 0; i < n; i++) begin
            seq.push_back(v);
            v = ~v;
        end
    endtask

    task automatic add_const(input int n, input bit v);
        for (int i = 0; i < n; i++) seq.push_back(v);
    endtask

    // Holds each entry of seq on raw_bit for one sampling period; hs_strobe pulses
    // ready only on the edge of that strobe number.
    task automatic feed(input bit rdy, input int hs_strobe);
        for (int n = 0; n < seq.size(); n++) begin
            raw_bit = seq[n];
            for (int j = 0; j < DIV; j++) begin
                bus.ready = rdy || (hs_strobe == n + 1 && j == DIV - 1);
                step(1);
            end
        end
        seq.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        raw_bit   = 1'b0;
        bus.ready = 1'b0;
        step(3);
        @(negedge clk);
        check("reset_data", bus.data, '0);
        check("reset_state", state_dbg, ST_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // alternating stream, ready high: 0xAA words every WIDTH*DIV cycles
        add_alt(40, 1'b1);
        start();
        feed(1'b1, 0);
        idle(2);

        // back-pressure for 100 cycles, then release
        add_alt(37, 1'b1);
        start();
        feed(1'b0, 0);
        add_alt(20, 1'b1);
        feed(1'b1, 0);
        idle(2);

        // stuck-at-one input faults on the RCT_LIMIT-th strobe and stays sticky
        add_const(10, 1'b1);
        start();
        feed(1'b1, 0);
        @(negedge clk);
        check("fault_sticky", fault, 1'b1);
        @(posedge clk);
        #1;
        idle(2);

        // fault on the strobe that completes the first word
        add_alt(6, 1'b1);
        add_const(6, 1'b1);
        add_alt(4, 1'b0);
        start();
        feed(1'b1, 0);
        idle(2);

        // fault on the same edge as a handshake
        add_alt(12, 1'b1);
        add_const(8, 1'b0);
        start();
        feed(1'b0, 17);
        idle(2);

        // reset mid-collect, then a full restart
        add_alt(7, 1'b1);
        start();
        feed(1'b1, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        add_alt(20, 1'b1);
        start();
        feed(1'b1, 0);
        idle(2);

        // enable dropped mid-collect, then a full restart
        add_alt(7, 1'b0);
        start();
        feed(1'b1, 0);
        idle(1);
        add_alt(20, 1'b0);
        start();
        feed(1'b1, 0);
        idle(2);

        // runs of RCT_LIMIT-1 equal samples never fault
        for (int r = 0; r < 10; r++) add_const(RCT_LIMIT - 1, r[0]);
        start();
        feed(1'b1, 0);
        idle(2);

        // random raw bits, ready, enable drops and occasional reset
        for (int c = 0; c < 8000; c++) begin
            raw_bit   = 1'($urandom_range(0, 1));
            bus.ready = ($urandom_range(0, 3) != 0);
            en        = !(m_fault && $urandom_range(0, 7) == 0) && ($urandom_range(0, 499) != 0);
            rst       = ($urandom_range(0, 1999) == 0);
            step(1);
        end
        rst = 1'b0;

        idle(3);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
